// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: classifies high pulses into bits, packs 24-bit GRB words
// and commits up to eight RGB words per frame into bus-readable registers.
module ws2812b_rx #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BIT_THRESH_NS = 600,
    parameter int MIN_HIGH_NS   = 150,
    parameter int MAX_HIGH_NS   = 2000,
    parameter int GAP_US        = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        we,
    input  logic        re,
    input  logic        ws_in,
    output logic        irq
);

    localparam int CYC_PER_KHZ = CLK_FREQ / 1000;
    localparam int GAP_CYC     = CYC_PER_KHZ * GAP_US / 1000;
    localparam int THR_CYC     = CYC_PER_KHZ * BIT_THRESH_NS / 1000000;
    localparam int MIN_CYC     = CYC_PER_KHZ * MIN_HIGH_NS / 1000000;
    localparam int MAX_CYC     = CYC_PER_KHZ * MAX_HIGH_NS / 1000000;

    localparam logic [15:0] GAP_C = 16'(GAP_CYC);
    localparam logic [16:0] THR_C = 17'(THR_CYC);
    localparam logic [16:0] MIN_C = 17'(MIN_CYC);
    localparam logic [16:0] MAX_C = 17'(MAX_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10,
        S_SYNC = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        ws_meta_q, ws_meta_d;
    logic        ws_s_q, ws_s_d;
    logic        ws_prev_q, ws_prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic [23:0] shadow_q [8];
    logic [23:0] shadow_d [8];
    logic [23:0] led_q [8];
    logic [23:0] led_d [8];
    logic [3:0]  count_q, count_d;
    logic        frame_valid_q, frame_valid_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    logic        rise, fall;
    logic [16:0] hi_len;
    logic        cnt_clr, bit_take, bit_val, abort, gap_end;
    logic        set_valid, set_ovf, set_err;
    logic        sts_wr;
    logic [23:0] new_word;
    logic        unused_bits;

    assign unused_bits = ^{re, write_data[31:10], write_data[7:1]};

    assign rise   = ws_s_q & ~ws_prev_q;
    assign fall   = ~ws_s_q & ws_prev_q;
    // Number of high samples seen before the current cycle of a pulse.
    assign hi_len = {1'b0, cnt_q} + 17'd1;
    assign sts_wr = we && (address == 8'h20);
    assign irq    = frame_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_SYNC;
            ws_meta_q     <= 1'b0;
            ws_s_q        <= 1'b0;
            ws_prev_q     <= 1'b0;
            cnt_q         <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            shadow_q      <= '{default: '0};
            led_q         <= '{default: '0};
            count_q       <= '0;
            frame_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ws_meta_q     <= ws_meta_d;
            ws_s_q        <= ws_s_d;
            ws_prev_q     <= ws_prev_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shadow_q      <= shadow_d;
            led_q         <= led_d;
            count_q       <= count_d;
            frame_valid_q <= frame_valid_d;
            ovf_q         <= ovf_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC: begin
                if (!ws_s_q && cnt_q >= GAP_C) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (rise) state_d = S_HIGH;
            end
            S_HIGH: begin
                if (hi_len >= MAX_C) begin
                    state_d = S_SYNC;
                end else if (fall) begin
                    state_d = (hi_len < MIN_C) ? S_SYNC : S_LOW;
                end
            end
            S_LOW: begin
                // A rise on the very cycle the gap completes starts the next frame.
                if (rise) state_d = S_HIGH;
                else if (cnt_q >= GAP_C) state_d = S_IDLE;
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_comb begin
        cnt_clr  = rise | fall;
        bit_take = 1'b0;
        bit_val  = 1'b0;
        abort    = 1'b0;
        gap_end  = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (ws_s_q) cnt_clr = 1'b1;
            end
            S_HIGH: begin
                if (hi_len >= MAX_C) begin
                    abort = 1'b1;
                end else if (fall) begin
                    if (hi_len < MIN_C) begin
                        abort = 1'b1;
                    end else begin
                        bit_take = 1'b1;
                        bit_val  = (hi_len >= THR_C);
                    end
                end
            end
            S_LOW: begin
                if (cnt_q >= GAP_C) gap_end = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ws_meta_d  = ws_in;
        ws_s_d     = ws_meta_q;
        ws_prev_d  = ws_s_q;
        cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shadow_d   = shadow_q;
        led_d      = led_q;
        count_d    = count_q;
        set_valid  = 1'b0;
        set_ovf    = 1'b0;
        set_err    = 1'b0;
        new_word   = {shift_q[22:0], bit_val};

        if (cnt_clr) cnt_d = '0;

        if (bit_take) begin
            shift_d = new_word;
            if (bit_cnt_q == 5'd23) begin
                bit_cnt_d = '0;
                // Wire order is G,R,B; registers hold R,G,B.
                if (word_cnt_q < 4'd8) begin
                    shadow_d[word_cnt_q[2:0]] = {new_word[15:8], new_word[23:16], new_word[7:0]};
                end else begin
                    set_ovf = 1'b1;
                end
                if (word_cnt_q != 4'd9) word_cnt_d = word_cnt_q + 4'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end

        if (abort) begin
            set_err    = 1'b1;
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end

        if (gap_end) begin
            if (bit_cnt_q != 5'd0) set_err = 1'b1;
            if (word_cnt_q != 4'd0) begin
                for (int i = 0; i < 8; i++) begin
                    if (4'(i) < word_cnt_q) led_d[i] = shadow_q[i];
                end
                count_d   = (word_cnt_q > 4'd8) ? 4'd8 : word_cnt_q;
                set_valid = 1'b1;
            end
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end

        // Internal set takes priority over a simultaneous software clear.
        frame_valid_d = set_valid | (frame_valid_q & ~(sts_wr & write_data[0]));
        ovf_d         = set_ovf   | (ovf_q & ~(sts_wr & write_data[8]));
        err_d         = set_err   | (err_q & ~(sts_wr & write_data[9]));
    end

    always_comb begin
        read_data = '0;
        if (address == 8'h20) begin
            read_data = {20'b0, state_q, err_q, ovf_q, 3'b0, count_q, frame_valid_q};
        end else if (address[7:5] == 3'b000 && address[1:0] == 2'b00) begin
            read_data = {8'b0, led_q[address[4:2]]};
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: random pulse streams checked against a queue-based frame model.
module tb_ws2812b_rx;

    localparam int GAP    = 2000;
    localparam int MIN_HI = 7;
    localparam int THR    = 30;
    localparam int MAX_HI = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        we;
    logic        re;
    logic        ws_in;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [23:0] m_led [8];
    logic [3:0]  m_count;
    bit          m_valid, m_ovf, m_err, m_synced;
    bit          m_bits[$];

    ws2812b_rx dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .we         (we),
        .re         (re),
        .ws_in      (ws_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_led[i] = '0;
        m_count = '0; m_valid = 0; m_ovf = 0; m_err = 0; m_synced = 0;
        m_bits.delete();
    endtask

    task automatic model_pulse(input int hi);
        if (!m_synced) return;
        if (hi < MIN_HI || hi >= MAX_HI) begin
            m_err = 1; m_synced = 0; m_bits.delete();
            return;
        end
        m_bits.push_back(hi >= THR);
        if (m_bits.size() % 24 == 0 && m_bits.size() / 24 > 8) m_ovf = 1;
    endtask

    task automatic model_gap();
        int nw;
        logic [23:0] grb;
        if (!m_synced) begin
            m_synced = 1;
            return;
        end
        nw = m_bits.size() / 24;
        if (m_bits.size() % 24 != 0) m_err = 1;
        if (nw > 0) begin
            for (int w = 0; w < nw && w < 8; w++) begin
                grb = '0;
                for (int b = 0; b < 24; b++) grb = {grb[22:0], m_bits[w*24+b]};
                m_led[w] = {grb[15:8], grb[23:16], grb[7:0]};
            end
            m_count = (nw > 8) ? 4'd8 : 4'(nw);
            m_valid = 1;
        end
        m_bits.delete();
    endtask

    function automatic logic [31:0] m_status();
        logic [1:0] st;
        st = m_synced ? 2'b00 : 2'b11;
        return {20'b0, st, m_err, m_ovf, 3'b0, m_count, m_valid};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic int rand_hi(input bit b);
        return b ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 7));
    endfunction

    task automatic send_pulse(input int hi, input int lo);
        ws_in = 1'b1;
        repeat (hi) @(negedge clk);
        ws_in = 1'b0;
        repeat (lo) @(negedge clk);
        model_pulse(hi);
    endtask

    task automatic send_word(input logic [23:0] grb);
        for (int i = 23; i >= 0; i--) send_pulse(rand_hi(grb[i]), int'($urandom_range(40, 6)));
    endtask

    task automatic send_rand_bits(input int n);
        for (int i = 0; i < n; i++) send_pulse(rand_hi(1'($urandom)), int'($urandom_range(40, 6)));
    endtask

    task automatic send_low(input int n);
        ws_in = 1'b0;
        repeat (n) @(negedge clk);
        if (n >= GAP) model_gap();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        address = a; re = 1'b1;
        #1;
        d = read_data;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        address = a; write_data = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic clear_flags(input logic [31:0] d);
        bus_write(8'h20, d);
        if (d[0]) m_valid = 0;
        if (d[8]) m_ovf = 0;
        if (d[9]) m_err = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd;
        bus_read(8'h20, rd);
        total++; if (rd !== m_status()) begin bad++; $display("FAIL reset_status: got %h want %h", rd, m_status()); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        bus_read(8'h1C, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_led7: got %h want 0", rd); end
        rst = 1'b0;
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd !== m_status()) begin bad++; $display("FAIL sync_status: got %h want %h", rd, m_status()); end
    endtask

    task automatic test_frame8();
        logic [23:0] w [8];
        logic [31:0] rd;
        bit b;
        w[0] = 24'h123456;
        w[7] = 24'hFFFFFF;
        for (int i = 1; i < 7; i++) w[i] = 24'($urandom);
        for (int k = 0; k < 8; k++) begin
            for (int i = 23; i >= 0; i--) begin
                b = w[k][i];
                if (k == 7 && i == 0) send_pulse(40, 0);
                else send_pulse(b ? 40 : 20, b ? 22 : 42);
            end
        end
        @(posedge clk);
        repeat (GAP + 2) @(posedge clk);
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
        @(posedge clk);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_latency: got %b want 1", irq); end
        @(negedge clk);
        repeat (500) @(negedge clk);
        model_gap();
        bus_read(8'h00, rd);
        total++; if (rd !== 32'h00341256) begin bad++; $display("FAIL frame8_led0: got %h want 00341256", rd); end
        bus_read(8'h1C, rd);
        total++; if (rd !== 32'h00FFFFFF) begin bad++; $display("FAIL frame8_led7: got %h want 00FFFFFF", rd); end
        bus_read(8'h20, rd);
        total++; if (rd !== 32'h011) begin bad++; $display("FAIL frame8_status: got %h want 011", rd); end
        for (int i = 1; i < 7; i++) begin
            bus_read(8'(i * 4), rd);
            total++; if (rd !== {8'h0, m_led[i]}) begin bad++; $display("FAIL frame8_led%0d: got %h want %h", i, rd, {8'h0, m_led[i]}); end
        end
    endtask

    task automatic test_threshold();
        logic [31:0] rd;
        clear_flags(32'h301);
        send_pulse(29, 30);
        send_pulse(30, 30);
        send_pulse(7, 30);
        send_rand_bits(21);
        send_low(2500);
        bus_read(8'h00, rd);
        total++; if (rd[15:13] !== 3'b010) begin bad++; $display("FAIL thresh_bits: got %b want 010", rd[15:13]); end
        total++; if (rd !== {8'h0, m_led[0]}) begin bad++; $display("FAIL thresh_led0: got %h want %h", rd, {8'h0, m_led[0]}); end
        clear_flags(32'h301);
        send_rand_bits(5);
        send_pulse(6, 30);
        send_rand_bits(10);
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd[9] !== 1'b1) begin bad++; $display("FAIL glitch_err: got %b want 1", rd[9]); end
        total++; if (rd !== m_status()) begin bad++; $display("FAIL glitch_status: got %h want %h", rd, m_status()); end
        for (int i = 0; i < 8; i++) begin
            bus_read(8'(i * 4), rd);
            total++; if (rd !== {8'h0, m_led[i]}) begin bad++; $display("FAIL glitch_led%0d: got %h want %h", i, rd, {8'h0, m_led[i]}); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        clear_flags(32'h301);
        for (int k = 0; k < 10; k++) send_word(24'($urandom));
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd[8] !== 1'b1 || rd[4:1] !== 4'd8) begin bad++; $display("FAIL ovf_flags: got %h want ovf=1 count=8", rd); end
        total++; if (rd !== m_status()) begin bad++; $display("FAIL ovf_status: got %h want %h", rd, m_status()); end
        for (int i = 0; i < 8; i++) begin
            bus_read(8'(i * 4), rd);
            total++; if (rd !== {8'h0, m_led[i]}) begin bad++; $display("FAIL ovf_led%0d: got %h want %h", i, rd, {8'h0, m_led[i]}); end
        end
        bus_write(8'h00, 32'hFFFFFFFF);
        bus_read(8'h00, rd);
        total++; if (rd !== {8'h0, m_led[0]}) begin bad++; $display("FAIL led_ro: got %h want %h", rd, {8'h0, m_led[0]}); end
        bus_read(8'h24, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped: got %h want 0", rd); end
        clear_flags(32'h301);
        bus_read(8'h20, rd);
        total++; if ((rd & 32'h301) !== 32'h0) begin bad++; $display("FAIL clear_flags: got %h want bits 0/8/9 clear", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b want 0", irq); end
    endtask

    task automatic test_partial();
        logic [31:0] rd;
        send_rand_bits(30);
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd[9] !== 1'b1 || rd[4:1] !== 4'd1) begin bad++; $display("FAIL partial_flags: got %h want err=1 count=1", rd); end
        total++; if (rd !== m_status()) begin bad++; $display("FAIL partial_status: got %h want %h", rd, m_status()); end
        for (int i = 0; i < 2; i++) begin
            bus_read(8'(i * 4), rd);
            total++; if (rd !== {8'h0, m_led[i]}) begin bad++; $display("FAIL partial_led%0d: got %h want %h", i, rd, {8'h0, m_led[i]}); end
        end
    endtask

    task automatic test_stuck();
        logic [31:0] rd;
        clear_flags(32'h301);
        send_word(24'($urandom));
        send_word(24'($urandom));
        send_pulse(100, 500);
        send_word(24'($urandom));
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd[9] !== 1'b1 || rd[0] !== 1'b0) begin bad++; $display("FAIL stuck_flags: got %h want err=1 valid=0", rd); end
        total++; if (rd !== m_status()) begin bad++; $display("FAIL stuck_status: got %h want %h", rd, m_status()); end
        send_word(24'($urandom));
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd !== m_status()) begin bad++; $display("FAIL resync_status: got %h want %h", rd, m_status()); end
        bus_read(8'h00, rd);
        total++; if (rd !== {8'h0, m_led[0]}) begin bad++; $display("FAIL resync_led0: got %h want %h", rd, {8'h0, m_led[0]}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        send_rand_bits(5);
        ws_in = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        address = 8'h20;
        #1;
        total++; if (read_data !== m_status()) begin bad++; $display("FAIL rstmid_status: got %h want %h", read_data, m_status()); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq: got %b want 0", irq); end
        address = 8'h00;
        #1;
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rstmid_led0: got %h want 0", read_data); end
        @(negedge clk);
        ws_in = 1'b0;
        rst = 1'b0;
        send_word(24'($urandom));
        send_low(2500);
        bus_read(8'h20, rd);
        total++; if (rd !== m_status()) begin bad++; $display("FAIL nosync_status: got %h want %h", rd, m_status()); end
        bus_read(8'h00, rd);
        total++; if (rd !== {8'h0, m_led[0]}) begin bad++; $display("FAIL nosync_led0: got %h want %h", rd, {8'h0, m_led[0]}); end
        send_word(24'($urandom));
        send_low(2500);
        bus_read(8'h00, rd);
        total++; if (rd !== {8'h0, m_led[0]}) begin bad++; $display("FAIL after_rst_led0: got %h want %h", rd, {8'h0, m_led[0]}); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL after_rst_irq: got %b want 1", irq); end
    endtask

    initial begin
        rst = 1'b1; address = '0; write_data = '0; we = 1'b0; re = 1'b0; ws_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_frame8();
        test_threshold();
        test_overflow();
        test_partial();
        test_stuck();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
